// File: rtl/wb_cmd_sequencer_pkg.sv
// wb_cmd_sequencer_pkg -- shared types and widths for the command sequencer.
//   state_e : sequencer FSM encoding (IDLE -> LOAD -> RUN -> DRAIN -> IDLE)
//   OPC_W   : opcode width
//   IDX_W   : operand index width
package wb_cmd_sequencer_pkg;

  localparam int OPC_W = 8;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/wb_cmd_sequencer_edge_detect.sv
// wb_edge_detect -- registered rising-edge detector.
//   clk  : clock
//   rst  : synchronous active-high reset (clears history and output)
//   sig  : level input
//   rise : one-cycle pulse, the cycle after sig is first seen high
module wb_edge_detect
  import wb_cmd_sequencer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      prev <= sig;
      rise <= sig & ~prev;
    end
  end

endmodule

// File: rtl/wb_cmd_sequencer.sv
// wb_cmd_sequencer -- host-facing command sequencer for a compute engine.
// Host writes an opcode, then NUM_OPERANDS data words which are streamed to
// the engine; after eng_start the engine returns up to NUM_RESULTS words,
// which the host reads back one per read event.
// Ports:
//   wb_clk_i / wb_rst_i       : clock, synchronous active-high reset
//   config_en, input_ready,
//   rd_strobe, wishbone_data  : host write/read requests and write data
//   output_ready, wishbone_output : result word presented to host in DRAIN
//   eng_opcode, eng_operand_we, eng_operand_idx, eng_operand, eng_start,
//   eng_abort                 : engine command side
//   eng_result_valid, eng_result, eng_done : engine result side
//   busy, err                 : status (err is sticky until next opcode in IDLE)
// Optional feature: define SEQ_TIMEOUT_EN to enable the RUN watchdog that
// aborts the engine after TIMEOUT_CYCLES RUN cycles without eng_done.
module wb_cmd_sequencer
  import wb_cmd_sequencer_pkg::*;
#(
  parameter int NUM_OPERANDS   = 4,
  parameter int NUM_RESULTS    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             config_en,
  input  logic             input_ready,
  input  logic             rd_strobe,
  input  logic [31:0]      wishbone_data,
  output logic             output_ready,
  output logic [31:0]      wishbone_output,
  output logic [OPC_W-1:0] eng_opcode,
  output logic             eng_operand_we,
  output logic [IDX_W-1:0] eng_operand_idx,
  output logic [31:0]      eng_operand,
  output logic             eng_start,
  input  logic             eng_result_valid,
  input  logic [31:0]      eng_result,
  input  logic             eng_done,
  output logic             eng_abort,
  output logic             busy,
  output logic             err
);

  localparam int CNT_W = $clog2(NUM_OPERANDS + 1);
  localparam int PTR_W = $clog2(NUM_RESULTS + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] op_cnt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [31:0]      res_buf [NUM_RESULTS];

  logic wr_rise, rd_rise;
  logic opc_wr, dat_wr, load_done, last_rd, tmo_hit;

  wb_edge_detect u_wr_edge (.clk(wb_clk_i), .rst(wb_rst_i), .sig(input_ready), .rise(wr_rise));
  wb_edge_detect u_rd_edge (.clk(wb_clk_i), .rst(wb_rst_i), .sig(rd_strobe),   .rise(rd_rise));

  // Write data and config_en are sampled in the cycle the registered edge pulse is high.
  assign opc_wr = wr_rise &  config_en;
  assign dat_wr = wr_rise & ~config_en;

  // The strobe for the last operand is on the wire now; start follows next cycle.
  // A concurrent opcode write restarts loading and wins.
  assign load_done = (state_q == LOAD) && eng_operand_we && !opc_wr &&
                     (op_cnt == CNT_W'(NUM_OPERANDS));
  assign last_rd   = rd_rise && (rd_ptr == PTR_W'(NUM_RESULTS - 1));

`ifdef SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  // The TIMEOUT_CYCLES-th RUN cycle without completion.
  assign tmo_hit = (state_q == RUN) && !eng_done && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit   = 1'b0;
  assign eng_abort = 1'b0;
`endif

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (opc_wr)    state_d = LOAD;
      LOAD:  if (load_done) state_d = RUN;
      RUN:   if (eng_done)  state_d = DRAIN;
             else if (tmo_hit) state_d = IDLE;
      DRAIN: if (last_rd)   state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy            = (state_q != IDLE);
    output_ready    = (state_q == DRAIN);
    wishbone_output = (state_q == DRAIN) ? res_buf[rd_ptr] : 32'd0;
  end

  // Datapath and registered strobes
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      eng_opcode      <= '0;
      eng_operand_we  <= 1'b0;
      eng_operand_idx <= '0;
      eng_operand     <= '0;
      eng_start       <= 1'b0;
      err             <= 1'b0;
      op_cnt          <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      for (int i = 0; i < NUM_RESULTS; i++) res_buf[i] <= '0;
`ifdef SEQ_TIMEOUT_EN
      eng_abort       <= 1'b0;
      tmo_cnt         <= '0;
`endif
    end else begin
      eng_operand_we <= 1'b0;
      eng_start      <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      eng_abort      <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (opc_wr) begin
            eng_opcode <= wishbone_data[OPC_W-1:0];
            op_cnt     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            err        <= 1'b0;
            for (int i = 0; i < NUM_RESULTS; i++) res_buf[i] <= '0;
          end
        end
        LOAD: begin
          if (opc_wr) begin
            eng_opcode <= wishbone_data[OPC_W-1:0];
            op_cnt     <= '0;
          end else if (dat_wr && (op_cnt < CNT_W'(NUM_OPERANDS))) begin
            eng_operand_we  <= 1'b1;
            eng_operand_idx <= IDX_W'(op_cnt);
            eng_operand     <= wishbone_data;
            op_cnt          <= op_cnt + CNT_W'(1);
          end
          if (load_done) eng_start <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        RUN: begin
          // A result coincident with eng_done is still captured here.
          if (eng_result_valid) begin
            if (wr_ptr < PTR_W'(NUM_RESULTS)) begin
              res_buf[wr_ptr] <= eng_result;
              wr_ptr          <= wr_ptr + PTR_W'(1);
            end else begin
              err <= 1'b1;
            end
          end
          if (wr_rise) err <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (tmo_hit) begin
            eng_abort <= 1'b1;
            err       <= 1'b1;
          end
`endif
        end
        DRAIN: begin
          if (rd_rise) rd_ptr <= rd_ptr + PTR_W'(1);
          if (wr_rise) err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_sequencer.sv
// tb_wb_cmd_sequencer -- directed self-checking bench for wb_cmd_sequencer.
// Build with SEQ_TIMEOUT_EN defined to exercise the watchdog (TIMEOUT_CYCLES=16).
module tb_wb_cmd_sequencer;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        config_en = 1'b0;
  logic        input_ready = 1'b0;
  logic        rd_strobe = 1'b0;
  logic [31:0] wishbone_data = '0;
  logic        output_ready;
  logic [31:0] wishbone_output;
  logic [7:0]  eng_opcode;
  logic        eng_operand_we;
  logic [3:0]  eng_operand_idx;
  logic [31:0] eng_operand;
  logic        eng_start;
  logic        eng_result_valid = 1'b0;
  logic [31:0] eng_result = '0;
  logic        eng_done = 1'b0;
  logic        eng_abort;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  wb_cmd_sequencer #(.NUM_OPERANDS(4), .NUM_RESULTS(2), .TIMEOUT_CYCLES(16)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .config_en(config_en),
    .input_ready(input_ready), .rd_strobe(rd_strobe), .wishbone_data(wishbone_data),
    .output_ready(output_ready), .wishbone_output(wishbone_output),
    .eng_opcode(eng_opcode), .eng_operand_we(eng_operand_we),
    .eng_operand_idx(eng_operand_idx), .eng_operand(eng_operand),
    .eng_start(eng_start), .eng_result_valid(eng_result_valid),
    .eng_result(eng_result), .eng_done(eng_done), .eng_abort(eng_abort),
    .busy(busy), .err(err)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns in the cycle where the write's effect is visible; caller ticks once more
  // before the next host request so input_ready is seen low in between.
  task automatic host_write(input logic cfg, input logic [31:0] d);
    config_en = cfg; wishbone_data = d; input_ready = 1'b1;
    tick(); tick();
    input_ready = 1'b0;
  endtask

  task automatic host_read();
    rd_strobe = 1'b1;
    tick(); tick();
    rd_strobe = 1'b0;
  endtask

  // Opcode + four operands; returns in the first RUN cycle (eng_start high).
  task automatic load_cmd(input logic [7:0] opc, input logic [31:0] base);
    host_write(1'b1, {24'd0, opc}); tick();
    for (int i = 0; i < 4; i++) begin
      host_write(1'b0, base + i); tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) tick();
    wb_rst_i = 1'b0;
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_rdy", {31'd0, output_ready}, 32'd0);
    check("rst_out", wishbone_output, 32'd0);
    check("rst_opcode", {24'd0, eng_opcode}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);

    // Data write and read in IDLE are ignored
    host_write(1'b0, 32'h77); tick();
    host_read(); tick();
    check("idle_ign_busy", {31'd0, busy}, 32'd0);
    check("idle_ign_we", {31'd0, eng_operand_we}, 32'd0);

    // Opcode 0x21 then operands 1..4
    host_write(1'b1, 32'h21);
    check("t1_opcode", {24'd0, eng_opcode}, 32'h21);
    check("t1_busy", {31'd0, busy}, 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      host_write(1'b0, i + 1);
      check("t1_we", {31'd0, eng_operand_we}, 32'd1);
      check("t1_idx", {28'd0, eng_operand_idx}, i);
      check("t1_operand", eng_operand, i + 1);
      check("t1_no_start", {31'd0, eng_start}, 32'd0);
      tick();
      check("t1_we_1cyc", {31'd0, eng_operand_we}, 32'd0);
    end
    check("t1_start", {31'd0, eng_start}, 32'd1);
    check("t1_busy_run", {31'd0, busy}, 32'd1);
    tick();
    check("t1_start_1cyc", {31'd0, eng_start}, 32'd0);

    // Engine returns 0xAAAA, 0x5555, done
    eng_result_valid = 1'b1; eng_result = 32'hAAAA; tick();
    eng_result = 32'h5555; tick();
    eng_result_valid = 1'b0; eng_done = 1'b1; tick();
    eng_done = 1'b0;
    check("t2_out_rdy", {31'd0, output_ready}, 32'd1);
    check("t2_rd0", wishbone_output, 32'hAAAA);
    host_read();
    check("t2_rd1", wishbone_output, 32'h5555);
    check("t2_out_rdy1", {31'd0, output_ready}, 32'd1);
    tick();
    host_read();
    check("t2_idle_rdy", {31'd0, output_ready}, 32'd0);
    check("t2_idle_busy", {31'd0, busy}, 32'd0);
    check("t2_err", {31'd0, err}, 32'd0);
    tick();

    // Single result coincident with done
    load_cmd(8'h33, 32'h10); tick();
    eng_result_valid = 1'b1; eng_result = 32'h1234; eng_done = 1'b1; tick();
    eng_result_valid = 1'b0; eng_done = 1'b0;
    check("t3_out_rdy", {31'd0, output_ready}, 32'd1);
    check("t3_rd0", wishbone_output, 32'h1234);
    host_read();
    check("t3_rd1_zero", wishbone_output, 32'd0);
    check("t3_err", {31'd0, err}, 32'd0);
    tick();
    host_read();
    check("t3_idle", {31'd0, busy}, 32'd0);
    tick();

    // Opcode write during RUN
    load_cmd(8'h44, 32'h20); tick();
    host_write(1'b1, 32'h99);
    check("t4_opcode", {24'd0, eng_opcode}, 32'h44);
    check("t4_err", {31'd0, err}, 32'd1);
    check("t4_busy", {31'd0, busy}, 32'd1);
    check("t4_out_rdy", {31'd0, output_ready}, 32'd0);
    tick();
    eng_done = 1'b1; tick(); eng_done = 1'b0;
    check("t4_drain_out", wishbone_output, 32'd0);
    host_read(); tick(); host_read(); tick();
    check("t4_idle", {31'd0, busy}, 32'd0);
    check("t4_err_sticky", {31'd0, err}, 32'd1);

`ifdef SEQ_TIMEOUT_EN
    // Watchdog: no eng_done, abort after 16 RUN cycles
    load_cmd(8'h55, 32'h30);
    check("t5_err_clr", {31'd0, err}, 32'd0);
    for (int i = 1; i < 16; i++) begin
      tick();
      check("t5_no_abort", {31'd0, eng_abort}, 32'd0);
      check("t5_run_busy", {31'd0, busy}, 32'd1);
    end
    tick();
    check("t5_abort", {31'd0, eng_abort}, 32'd1);
    check("t5_err", {31'd0, err}, 32'd1);
    check("t5_idle", {31'd0, busy}, 32'd0);
    tick();
    check("t5_abort_1cyc", {31'd0, eng_abort}, 32'd0);
`else
    // Without the watchdog RUN waits indefinitely
    load_cmd(8'h55, 32'h30);
    repeat (40) tick();
    check("t5_no_abort", {31'd0, eng_abort}, 32'd0);
    check("t5_still_run", {31'd0, busy}, 32'd1);
    eng_done = 1'b1; tick(); eng_done = 1'b0;
    host_read(); tick(); host_read(); tick();
    check("t5_idle", {31'd0, busy}, 32'd0);
`endif

    // Reset after the second operand
    host_write(1'b1, 32'h66); tick();
    host_write(1'b0, 32'h1); tick();
    host_write(1'b0, 32'h2); tick();
    wb_rst_i = 1'b1; tick();
    wb_rst_i = 1'b0;
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_opcode", {24'd0, eng_opcode}, 32'd0);
    check("t6_idx", {28'd0, eng_operand_idx}, 32'd0);
    check("t6_operand", eng_operand, 32'd0);
    check("t6_strobes", {29'd0, eng_operand_we, eng_start, eng_abort}, 32'd0);
    check("t6_err", {31'd0, err}, 32'd0);
    check("t6_out", {31'd0, output_ready}, 32'd0);
    tick();
    host_write(1'b0, 32'h3);
    check("t6_ign_we", {31'd0, eng_operand_we}, 32'd0);
    check("t6_ign_busy", {31'd0, busy}, 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_cmd_sequencer.md
WB_CMD_SEQUENCER -- requirements
Module: wb_cmd_sequencer

Interface
REQ-001 SHALL have parameter NUM_OPERANDS, default 4, meaning operand words loaded per command (range 1..16).
REQ-002 SHALL have parameter NUM_RESULTS, default 2, meaning result words buffered per command (range 1..8).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning RUN watchdog limit (used only under SEQ_TIMEOUT_EN).
REQ-004 SHALL use one clock and a synchronous, active-high reset; no other clock or reset is permitted.
REQ-005 SHALL have port wb_clk_i  in  1  clock; all state changes on its rising edge.
REQ-006 SHALL have port wb_rst_i  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port config_en  in  1  host request targets the opcode address (level).
REQ-008 SHALL have port input_ready  in  1  host write request active (level, held until ack).
REQ-009 SHALL have port rd_strobe  in  1  host read request active (level).
REQ-010 SHALL have port wishbone_data  in  32  host write data.
REQ-011 SHALL have port output_ready  out  1  result word valid on wishbone_output.
REQ-012 SHALL have port wishbone_output  out  32  current result word.
REQ-013 SHALL have port eng_opcode  out  8  latched opcode.
REQ-014 SHALL have port eng_operand_we  out  1  one-cycle operand write strobe.
REQ-015 SHALL have port eng_operand_idx  out  4  operand index.
REQ-016 SHALL have port eng_operand  out  32  operand data.
REQ-017 SHALL have port eng_start  out  1  one-cycle engine start pulse.
REQ-018 SHALL have port eng_result_valid  in  1  eng_result valid this cycle.
REQ-019 SHALL have port eng_result  in  32  engine result word.
REQ-020 SHALL have port eng_done  in  1  engine finished (pulse).
REQ-021 SHALL have port eng_abort  out  1  one-cycle abort pulse.
REQ-022 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-023 SHALL have port err  out  1  sticky protocol error.

Function
REQ-024 SHALL detect a host write as a rising edge of input_ready and sample wishbone_data and config_en on the following cycle; a write with config_en=1 is an opcode write, otherwise a data write.
REQ-025 SHALL detect a host read as a rising edge of rd_strobe; level-high cycles after the edge are not new events.
REQ-026 SHALL implement FSM IDLE->LOAD->RUN->DRAIN->IDLE.
REQ-027 In IDLE, an opcode write SHALL latch wishbone_data[7:0] into eng_opcode, clear the operand count, clear the result buffer and err, and enter LOAD; data writes and reads SHALL be ignored.
REQ-028 In LOAD, each data write SHALL produce eng_operand_we for exactly one cycle with eng_operand_idx equal to the count and eng_operand equal to the data, then increment the count.
REQ-029 After the NUM_OPERANDS-th operand strobe, eng_start SHALL pulse on the next cycle and the FSM SHALL enter RUN.
REQ-030 An opcode write in LOAD SHALL relatch the opcode, reset the count to 0 and remain in LOAD.
REQ-031 In RUN, each eng_result_valid SHALL write eng_result into buffer[wr_ptr] and increment wr_ptr; a result arriving when wr_ptr==NUM_RESULTS SHALL be dropped and set err.
REQ-032 eng_done SHALL move the FSM from RUN to DRAIN; when eng_result_valid and eng_done coincide, the result SHALL be captured first. Unfilled entries SHALL read as 0.
REQ-033 In DRAIN, output_ready SHALL be 1 and wishbone_output SHALL equal buffer[rd_ptr]; each host read SHALL increment rd_ptr; after NUM_RESULTS reads the FSM SHALL return to IDLE with output_ready=0.
REQ-034 An opcode write or data write in RUN or DRAIN SHALL be ignored and SHALL set err.
REQ-035 Strobe outputs (eng_operand_we, eng_start, eng_abort) SHALL never be high for more than one consecutive cycle.

Reset
REQ-036 Reset SHALL force IDLE; set all outputs to 0; and clear counters, pointers, buffer and edge-detect registers.
REQ-037 Reset asserted mid-LOAD/RUN/DRAIN SHALL abandon the command without eng_abort; the first event after deassertion SHALL be evaluated as in IDLE.

Configuration
REQ-038 With macro SEQ_TIMEOUT_EN defined: a counter SHALL clear on entry to RUN and increment each RUN cycle; when it reaches TIMEOUT_CYCLES without eng_done, eng_abort SHALL pulse, err SHALL set and the FSM SHALL enter IDLE.
REQ-039 Without SEQ_TIMEOUT_EN: no counter SHALL exist, eng_abort SHALL be tied 0, and RUN SHALL wait indefinitely.

Structure
REQ-040 The shared package SHALL hold the FSM state typedef/encoding, the opcode width (8) and the operand index width (4).
REQ-041 The design SHALL contain one sub-module, wb_edge_detect, instantiated for input_ready and rd_strobe; all other logic SHALL be flat.

Verification
REQ-042 The bench SHALL cover: opcode 0x21, data 1,2,3,4 -> four operand strobes idx 0..3, eng_start one cycle after the 4th, busy=1.
REQ-043 The bench SHALL cover: engine returns 0xAAAA then 0x5555 and done -> output_ready=1, reads return 0xAAAA then 0x5555, then IDLE.
REQ-044 The bench SHALL cover: result_valid coincident with done after a single result -> second read returns 0, err=0.
REQ-045 The bench SHALL cover: opcode write during RUN -> ignored, err=1, eng_opcode unchanged.
REQ-046 The bench SHALL cover, with SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, no eng_done -> eng_abort pulse at RUN cycle 16, err=1, IDLE.
REQ-047 The bench SHALL cover: reset after the 2nd operand -> all outputs 0, next data write ignored.
